pipeline_hazard_ctrl: RTL and testbench

- Central stall/flush/forward controller for the 5-stage core.
- Detects load-use hazards and resolves branch-taken flushes.
- Sequences multi-cycle data-memory accesses by freezing the pipeline, including the EX/MEM register, until memory responds.
- Drives operand-forwarding selects for the EX stage; adds a watchdog on memory waits.

---
 rtl/hazard_pkg.sv | 17 +
 rtl/pipeline_hazard_ctrl_fwd_select.sv | 28 ++
 rtl/pipeline_hazard_ctrl.sv | 145 ++++++++++++++
 tb/tb_pipeline_hazard_ctrl.sv | 238 +++++++++++++++++++++++
 4 files changed

// File: rtl/hazard_pkg.sv
// Shared types and constants for the pipeline hazard controller.
package hazard_pkg;

    typedef enum logic [1:0] {
        FWD_RF  = 2'b00,
        FWD_WB  = 2'b01,
        FWD_MEM = 2'b10
    } fwd_sel_t;

    typedef enum logic {
        RUN,
        MEM_WAIT
    } memctl_state_t;

    localparam logic [4:0] REG_X0 = 5'd0;

endpackage

// File: rtl/pipeline_hazard_ctrl_fwd_select.sv
// Operand-forwarding select for one EX-stage source register.
module fwd_select
    import hazard_pkg::*;
(
    input  logic [4:0] rs_e_i,
    input  logic [4:0] rd_m_i,
    input  logic       reg_write_m_i,
    input  logic       is_load_m_i,
    input  logic [4:0] rd_w_i,
    input  logic       reg_write_w_i,
    output logic [1:0] fwd_o
);

    fwd_sel_t sel;

    // A load in MEM has no ALU result to offer, so it falls through to WB.
    always_comb begin
        sel = FWD_RF;
        if (reg_write_m_i && !is_load_m_i && (rd_m_i != REG_X0) && (rd_m_i == rs_e_i)) begin
            sel = FWD_MEM;
        end else if (reg_write_w_i && (rd_w_i != REG_X0) && (rd_w_i == rs_e_i)) begin
            sel = FWD_WB;
        end
    end

    assign fwd_o = sel;

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Stall/flush/forward controller for the 5-stage core, with a memory-wait
// sequencer and a sticky watchdog on long data-memory accesses.
module pipeline_hazard_ctrl
    import hazard_pkg::*;
#(
    parameter int MAX_WAIT = 255
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [4:0] Rs1D,
    input  logic [4:0] Rs2D,
    input  logic [4:0] Rs1E,
    input  logic [4:0] Rs2E,
    input  logic [4:0] RdE,
    input  logic       RegWriteE,
    input  logic       isLoadE,
    input  logic       BranchTakenE,
    input  logic [4:0] RdM,
    input  logic       RegWriteM,
    input  logic       isLoadM,
    input  logic       WDMEM,
    input  logic [4:0] RdW,
    input  logic       RegWriteW,
    input  logic       mem_ready,
    output logic       StallF,
    output logic       StallD,
    output logic       FlushD,
    output logic       FlushE,
    output logic       HoldM,
    output logic       BubbleW,
    output logic [1:0] ForwardAE,
    output logic [1:0] ForwardBE,
    output logic       mem_busy,
    output logic       mem_timeout
);

    localparam int              CNT_W   = $clog2(MAX_WAIT + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_WAIT);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    memctl_state_t    state_q, state_d;
    logic [CNT_W-1:0] wait_cnt_q, wait_cnt_d;
    logic             mem_timeout_q, mem_timeout_d;

    logic       mem_access;
    logic       mem_stall;
    logic       load_use;
    logic [1:0] fwd_a, fwd_b;

    fwd_select u_fwd_a (
        .rs_e_i        (Rs1E),
        .rd_m_i        (RdM),
        .reg_write_m_i (RegWriteM),
        .is_load_m_i   (isLoadM),
        .rd_w_i        (RdW),
        .reg_write_w_i (RegWriteW),
        .fwd_o         (fwd_a)
    );

    fwd_select u_fwd_b (
        .rs_e_i        (Rs2E),
        .rd_m_i        (RdM),
        .reg_write_m_i (RegWriteM),
        .is_load_m_i   (isLoadM),
        .rd_w_i        (RdW),
        .reg_write_w_i (RegWriteW),
        .fwd_o         (fwd_b)
    );

    assign mem_access = isLoadM | WDMEM;
    assign mem_stall  = (state_q == MEM_WAIT) | (mem_access & ~mem_ready);
    assign load_use   = isLoadE & RegWriteE & (RdE != REG_X0) &
                        ((RdE == Rs1D) | (RdE == Rs2D));

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= RUN;
            wait_cnt_q    <= '0;
            mem_timeout_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            wait_cnt_q    <= wait_cnt_d;
            mem_timeout_q <= mem_timeout_d;
        end
    end

    // wait_cnt holds the number of stall cycles already spent on the current
    // access, so the cycle that enters MEM_WAIT counts as the first.
    always_comb begin
        state_d       = state_q;
        wait_cnt_d    = wait_cnt_q;
        mem_timeout_d = mem_timeout_q;
        if (state_q == RUN) begin
            if (mem_access && !mem_ready) begin
                state_d    = MEM_WAIT;
                wait_cnt_d = CNT_ONE;
            end
        end else begin
            if (mem_ready) begin
                state_d    = RUN;
                wait_cnt_d = '0;
            end else if (wait_cnt_q != CNT_MAX) begin
                wait_cnt_d = wait_cnt_q + CNT_ONE;
            end
        end
        if ((state_d == MEM_WAIT) && (wait_cnt_d == CNT_MAX)) begin
            mem_timeout_d = 1'b1;
        end
    end

    always_comb begin
        StallF    = 1'b0;
        StallD    = 1'b0;
        FlushD    = 1'b0;
        FlushE    = 1'b0;
        HoldM     = 1'b0;
        BubbleW   = 1'b0;
        ForwardAE = fwd_a;
        ForwardBE = fwd_b;
        mem_busy  = (state_q == MEM_WAIT);
        if (rst) begin
            FlushD    = 1'b1;
            FlushE    = 1'b1;
            BubbleW   = 1'b1;
            ForwardAE = FWD_RF;
            ForwardBE = FWD_RF;
            mem_busy  = 1'b0;
        end else if (mem_stall) begin
            StallF  = 1'b1;
            StallD  = 1'b1;
            HoldM   = 1'b1;
            BubbleW = 1'b1;
        end else if (BranchTakenE) begin
            FlushD = 1'b1;
            FlushE = 1'b1;
        end else if (load_use) begin
            StallF = 1'b1;
            StallD = 1'b1;
            FlushE = 1'b1;
        end
    end

    assign mem_timeout = mem_timeout_q;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Self-checking bench for pipeline_hazard_ctrl: directed scenarios plus
// randomized traffic compared every cycle against a behavioural model.
module tb_pipeline_hazard_ctrl;

    localparam int MAXW = 4;

    logic       clk = 1'b0;
    logic       rst;
    logic [4:0] Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW;
    logic       RegWriteE, isLoadE, BranchTakenE;
    logic       RegWriteM, isLoadM, WDMEM, RegWriteW, mem_ready;
    logic       StallF, StallD, FlushD, FlushE, HoldM, BubbleW;
    logic [1:0] ForwardAE, ForwardBE;
    logic       mem_busy, mem_timeout;

    int checks = 0;
    int errors = 0;
    bit started = 1'b0;

    // Model state: consecutive memory-stall cycles completed, sticky timeout.
    int m_n  = 0;
    bit m_to = 1'b0;

    pipeline_hazard_ctrl #(.MAX_WAIT(MAXW)) dut (
        .clk(clk), .rst(rst),
        .Rs1D(Rs1D), .Rs2D(Rs2D), .Rs1E(Rs1E), .Rs2E(Rs2E), .RdE(RdE),
        .RegWriteE(RegWriteE), .isLoadE(isLoadE), .BranchTakenE(BranchTakenE),
        .RdM(RdM), .RegWriteM(RegWriteM), .isLoadM(isLoadM), .WDMEM(WDMEM),
        .RdW(RdW), .RegWriteW(RegWriteW), .mem_ready(mem_ready),
        .StallF(StallF), .StallD(StallD), .FlushD(FlushD), .FlushE(FlushE),
        .HoldM(HoldM), .BubbleW(BubbleW), .ForwardAE(ForwardAE), .ForwardBE(ForwardBE),
        .mem_busy(mem_busy), .mem_timeout(mem_timeout)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [11:0] got, input logic [11:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%b expected=%b t=%0t", nm, got, exp, $time);
        end
    endtask

    task automatic chk1(input string nm, input logic got, input logic exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%b expected=%b t=%0t", nm, got, exp, $time);
        end
    endtask

    function automatic logic [1:0] m_fwd(input logic [4:0] rs);
        if (RegWriteM && !isLoadM && RdM != 5'd0 && RdM == rs) return 2'b10;
        if (RegWriteW && RdW != 5'd0 && RdW == rs) return 2'b01;
        return 2'b00;
    endfunction

    function automatic bit m_stall_now();
        return (m_n > 0) || ((isLoadM || WDMEM) && !mem_ready);
    endfunction

    function automatic logic [11:0] model_out();
        logic sf, sd, fd, fe, hm, bw, busy;
        logic [1:0] fa, fb;
        logic lu;
        sf = 0; sd = 0; fd = 0; fe = 0; hm = 0; bw = 0; busy = 0;
        fa = 2'b00; fb = 2'b00;
        lu = isLoadE && RegWriteE && RdE != 5'd0 && (RdE == Rs1D || RdE == Rs2D);
        if (rst) begin
            fd = 1; fe = 1; bw = 1;
        end else begin
            fa = m_fwd(Rs1E);
            fb = m_fwd(Rs2E);
            busy = (m_n > 0);
            if (m_stall_now()) begin
                sf = 1; sd = 1; hm = 1; bw = 1;
            end else if (BranchTakenE) begin
                fd = 1; fe = 1;
            end else if (lu) begin
                sf = 1; sd = 1; fe = 1;
            end
        end
        return {sf, sd, fd, fe, hm, bw, fa, fb, busy, m_to};
    endfunction

    always @(posedge clk) begin
        if (rst) begin
            m_n  <= 0;
            m_to <= 1'b0;
        end else if (m_stall_now()) begin
            if (mem_ready) begin
                m_n <= 0;
            end else begin
                m_n <= m_n + 1;
                if (m_n + 1 >= MAXW) m_to <= 1'b1;
            end
        end
    end

    always @(negedge clk) begin
        if (started) begin
            chk("cycle_outputs",
                {StallF, StallD, FlushD, FlushE, HoldM, BubbleW, ForwardAE, ForwardBE, mem_busy, mem_timeout},
                model_out());
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clr();
        Rs1D = 0; Rs2D = 0; Rs1E = 0; Rs2E = 0; RdE = 0; RdM = 0; RdW = 0;
        RegWriteE = 0; isLoadE = 0; BranchTakenE = 0;
        RegWriteM = 0; isLoadM = 0; WDMEM = 0; RegWriteW = 0; mem_ready = 1;
    endtask

    initial begin
        rst = 1'b1;
        clr();
        started = 1'b1;

        tick(); #2;
        chk("rst_flush", {9'b0, FlushD, FlushE, BubbleW}, 12'b111);
        chk("rst_stall", {9'b0, StallF, StallD, HoldM}, 12'b000);
        tick();
        rst = 1'b0;
        #2;
        chk("idle_all", {StallF, StallD, FlushD, FlushE, HoldM, BubbleW, ForwardAE, ForwardBE, mem_busy, mem_timeout}, 12'b0);
        tick();

        isLoadE = 1; RegWriteE = 1; RdE = 5; Rs2D = 5;
        #2;
        chk("lu_resp", {8'b0, StallF, StallD, FlushE, FlushD}, 12'b1110);
        tick();
        clr();
        #2;
        chk("lu_gone", {9'b0, StallF, StallD, FlushE}, 12'b0);
        isLoadE = 1; RegWriteE = 1; RdE = 0; Rs1D = 0;
        #2;
        chk1("lu_x0_nostall", StallF, 1'b0);
        tick();

        clr();
        isLoadM = 1; mem_ready = 0;
        for (int i = 0; i < 4; i++) begin
            if (i == 3) mem_ready = 1;
            #2;
            chk("memwait_stall", {8'b0, StallF, StallD, HoldM, BubbleW}, 12'b1111);
            chk1("memwait_busy", mem_busy, (i > 0));
            tick();
        end
        #2;
        chk("memwait_done", {9'b0, StallF, HoldM, mem_busy}, 12'b0);
        tick();

        clr();
        BranchTakenE = 1; isLoadE = 1; RegWriteE = 1; RdE = 3; Rs1D = 3;
        #2;
        chk("br_lu", {8'b0, FlushD, FlushE, StallF, StallD}, 12'b1100);
        tick();

        clr();
        BranchTakenE = 1; isLoadM = 1; mem_ready = 0;
        for (int i = 0; i < 3; i++) begin
            if (i == 2) mem_ready = 1;
            #2;
            chk1("br_in_wait_noflush", FlushD, 1'b0);
            tick();
        end
        isLoadM = 0;
        #2;
        chk("br_after_wait", {9'b0, FlushD, FlushE, StallF}, 12'b110);
        tick();

        clr();
        RdM = 7; RdW = 7; Rs1E = 7; RegWriteM = 1; RegWriteW = 1;
        #2;
        chk("fwdA_mem", {10'b0, ForwardAE}, 12'b10);
        isLoadM = 1;
        #2;
        chk("fwdA_wb_load", {10'b0, ForwardAE}, 12'b01);
        Rs1E = 0;
        #2;
        chk("fwdA_x0", {10'b0, ForwardAE}, 12'b00);
        isLoadM = 0; Rs2E = 7; RdM = 9;
        #2;
        chk("fwdB_wb", {10'b0, ForwardBE}, 12'b01);
        tick();

        clr();
        WDMEM = 1; mem_ready = 0;
        for (int i = 0; i < 5; i++) begin
            #2;
            chk1("timeout_rise", mem_timeout, (i == 4));
            tick();
        end
        mem_ready = 1;
        #2;
        chk1("timeout_sticky_ready", mem_timeout, 1'b1);
        tick();
        clr();
        #2;
        chk1("timeout_sticky_idle", mem_timeout, 1'b1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        #2;
        chk1("timeout_cleared", mem_timeout, 1'b0);

        for (int c = 0; c < 3000; c++) begin
            tick();
            rst          = ($urandom_range(0, 99) == 0);
            Rs1D         = 5'($urandom_range(0, 3));
            Rs2D         = 5'($urandom_range(0, 3));
            Rs1E         = 5'($urandom_range(0, 3));
            Rs2E         = 5'($urandom_range(0, 3));
            RdE          = 5'($urandom_range(0, 3));
            RdM          = 5'($urandom_range(0, 3));
            RdW          = 5'($urandom_range(0, 3));
            RegWriteE    = 1'($urandom_range(0, 1));
            isLoadE      = 1'($urandom_range(0, 1));
            BranchTakenE = ($urandom_range(0, 4) == 0);
            RegWriteM    = 1'($urandom_range(0, 1));
            isLoadM      = ($urandom_range(0, 3) == 0);
            WDMEM        = ($urandom_range(0, 3) == 0);
            RegWriteW    = 1'($urandom_range(0, 1));
            mem_ready    = ($urandom_range(0, 9) < 6);
        end
        tick();
        started = 1'b0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
